// File: rtl/frame_buffer_ctrl.sv
// frame_buffer_ctrl: single-frame pixel buffer with an inferred simple-dual-port
// RAM and an IDLE/LOAD/PROCESS/DISPLAY mode FSM.
// Ports: cfg_h/cfg_w/start set up a frame load; in_pixel/in_valid/in_ready is
// the raster input stream; proc_* is the edge-filter read/write port; disp_*
// is the scan-out read port; rd_data/rd_valid return reads two cycles after
// the coordinate; mode, frame_loaded and err (sticky) report status.
// Build option: define FB_BOUNDS_CHECK_EN to reject out-of-frame coordinates.
module frame_buffer_ctrl #(
    parameter int DATA_W  = 8,
    parameter int COORD_W = 16,
    parameter int ADDR_W  = 19,
    parameter int MAX_PIX = 307200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] cfg_h,
    input  logic [COORD_W-1:0] cfg_w,
    input  logic               start,
    input  logic [DATA_W-1:0]  in_pixel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] proc_rd_row,
    input  logic [COORD_W-1:0] proc_rd_col,
    input  logic [COORD_W-1:0] proc_wr_row,
    input  logic [COORD_W-1:0] proc_wr_col,
    input  logic [DATA_W-1:0]  proc_wr_data,
    input  logic               proc_wr_valid,
    input  logic               proc_done,
    input  logic [COORD_W-1:0] disp_row,
    input  logic [COORD_W-1:0] disp_col,
    output logic [DATA_W-1:0]  rd_data,
    output logic               rd_valid,
    output logic [1:0]         mode,
    output logic               frame_loaded,
    output logic               err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PROC = 2'd2,
        DISP = 2'd3
    } state_t;

    localparam int PW = 2 * COORD_W;
    localparam logic [PW-1:0] MAX_N = PW'(MAX_PIX);

    state_t state_q, state_d;
    logic [COORD_W-1:0] w_q;
    logic [ADDR_W-1:0]  cnt_q, last_q;
    logic [PW-1:0]      npix;
    logic               start_ok, cfg_bad;
    logic               load_wr, load_last;
    logic               rd_act, wr_act;
    logic [COORD_W-1:0] rd_row, rd_col;
    logic               rd_oob, wr_oob;
    logic               s1_we, s1_rv, s1_rej;
    logic               s2_rv, s2_rej;
    logic [ADDR_W-1:0]  s1_waddr, s1_raddr;
    logic [DATA_W-1:0]  s1_wdata, ram_q;
    logic               fl_q, err_q;
    logic [DATA_W-1:0]  mem [MAX_PIX];

    // Full-width product and sum, then truncated to the RAM address width.
    function automatic logic [ADDR_W-1:0] lin(
        input logic [COORD_W-1:0] r,
        input logic [COORD_W-1:0] c,
        input logic [COORD_W-1:0] w
    );
        return ADDR_W'(PW'(r) * PW'(w) + PW'(c));
    endfunction

    assign npix      = PW'(cfg_h) * PW'(cfg_w);
    assign cfg_bad   = (npix == '0) || (npix > MAX_N);
    assign start_ok  = start && ((state_q == IDLE) || (state_q == DISP));
    assign load_wr   = (state_q == LOAD) && in_valid;
    assign load_last = load_wr && (cnt_q == last_q);
    assign rd_act    = (state_q == PROC) || (state_q == DISP);
    assign wr_act    = (state_q == PROC) && proc_wr_valid;
    assign rd_row    = (state_q == PROC) ? proc_rd_row : disp_row;
    assign rd_col    = (state_q == PROC) ? proc_rd_col : disp_col;

`ifdef FB_BOUNDS_CHECK_EN
    logic [COORD_W-1:0] h_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q <= '0;
        end else if (start_ok && !cfg_bad) begin
            h_q <= cfg_h;
        end
    end

    assign rd_oob = (rd_row >= h_q) || (rd_col >= w_q);
    assign wr_oob = (proc_wr_row >= h_q) || (proc_wr_col >= w_q);
`else
    assign rd_oob = 1'b0;
    assign wr_oob = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DISP: if (start) state_d = cfg_bad ? IDLE : LOAD;
            LOAD:       if (load_last) state_d = PROC;
            PROC:       if (proc_done) state_d = DISP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            w_q      <= '0;
            cnt_q    <= '0;
            last_q   <= '0;
            fl_q     <= 1'b0;
            err_q    <= 1'b0;
            s1_we    <= 1'b0;
            s1_waddr <= '0;
            s1_wdata <= '0;
            s1_raddr <= '0;
            s1_rv    <= 1'b0;
            s1_rej   <= 1'b0;
            s2_rv    <= 1'b0;
            s2_rej   <= 1'b0;
        end else begin
            state_q <= state_d;
            fl_q    <= load_last;
            if (load_wr) cnt_q <= cnt_q + 1'b1;
            // An accepted start overrides any rejection seen in the same cycle.
            if (start_ok) begin
                err_q <= cfg_bad;
                if (!cfg_bad) begin
                    w_q    <= cfg_w;
                    last_q <= ADDR_W'(npix - 1'b1);
                    cnt_q  <= '0;
                end
            end else if ((rd_act && rd_oob) || (wr_act && wr_oob)) begin
                err_q <= 1'b1;
            end
            s1_we    <= load_wr || (wr_act && !wr_oob);
            s1_waddr <= (state_q == LOAD) ? cnt_q
                                          : lin(proc_wr_row, proc_wr_col, w_q);
            s1_wdata <= (state_q == LOAD) ? in_pixel : proc_wr_data;
            s1_raddr <= lin(rd_row, rd_col, w_q);
            s1_rv    <= rd_act;
            s1_rej   <= rd_oob;
            s2_rv    <= s1_rv;
            s2_rej   <= s1_rej;
        end
    end

    // Read and write in one block: a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (s1_we) mem[s1_waddr] <= s1_wdata;
        ram_q <= mem[s1_raddr];
    end

    assign rd_data      = (s2_rv && !s2_rej) ? ram_q : '0;
    assign rd_valid     = s2_rv;
    assign mode         = state_q;
    assign in_ready     = (state_q == LOAD);
    assign frame_loaded = fl_q;
    assign err          = err_q;

endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb_frame_buffer_ctrl: directed vector table plus random stimulus for
// frame_buffer_ctrl, checked against a behavioural frame/memory model.
module tb_frame_buffer_ctrl;

    localparam int DW = 8;
    localparam int CW = 16;
    localparam int AW = 19;
    localparam int MP = 307200;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] cfg_h, cfg_w;
    logic          start;
    logic [DW-1:0] in_pixel;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] proc_rd_row, proc_rd_col;
    logic [CW-1:0] proc_wr_row, proc_wr_col;
    logic [DW-1:0] proc_wr_data;
    logic          proc_wr_valid, proc_done;
    logic [CW-1:0] disp_row, disp_col;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [1:0]    mode;
    logic          frame_loaded, err;

    always #5 clk = ~clk;

    frame_buffer_ctrl #(
        .DATA_W(DW), .COORD_W(CW), .ADDR_W(AW), .MAX_PIX(MP)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_h(cfg_h), .cfg_w(cfg_w), .start(start),
        .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
        .proc_rd_row(proc_rd_row), .proc_rd_col(proc_rd_col),
        .proc_wr_row(proc_wr_row), .proc_wr_col(proc_wr_col),
        .proc_wr_data(proc_wr_data), .proc_wr_valid(proc_wr_valid),
        .proc_done(proc_done),
        .disp_row(disp_row), .disp_col(disp_col),
        .rd_data(rd_data), .rd_valid(rd_valid), .mode(mode),
        .frame_loaded(frame_loaded), .err(err)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: frame parameters, mode and a sparse pixel memory.
    logic [7:0] ref_mem [int];
    int   m_mode, m_h, m_w, m_np, m_cnt;
    bit   m_err, m_fl;
    bit   pv, pk;
    logic [7:0] pd;

    typedef struct {
        logic [15:0] rr, rc, wr, wc;
        logic [7:0]  wd;
        logic        wv, dn;
        logic [15:0] dr, dc;
        logic [1:0]  e_mode;
        logic        e_v;
        logic [7:0]  e_d;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_h = 0; m_w = 0; m_np = 0; m_cnt = 0;
        m_err = 0; m_fl = 0; pv = 0; pk = 0; pd = '0;
    endtask

    task automatic quiet();
        start = 0; cfg_h = '0; cfg_w = '0; in_pixel = '0; in_valid = 0;
        proc_rd_row = '0; proc_rd_col = '0; proc_wr_row = '0;
        proc_wr_col = '0; proc_wr_data = '0; proc_wr_valid = 0;
        proc_done = 0; disp_row = '0; disp_col = '0;
    endtask

    // One clock: update the model with this cycle's inputs, clock, compare.
    task automatic cyc();
        longint rr, rc, ra, wa, np;
        bit cur_v, cur_k, rej_r, rej_w;
        logic [7:0] cur_d;
        rr = (m_mode == 2) ? proc_rd_row : disp_row;
        rc = (m_mode == 2) ? proc_rd_col : disp_col;
        ra = (rr * m_w + rc) % (longint'(1) << AW);
        wa = (longint'(proc_wr_row) * m_w + proc_wr_col) % (longint'(1) << AW);
        rej_r = 0;
        rej_w = 0;
`ifdef FB_BOUNDS_CHECK_EN
        rej_r = (rr >= m_h) || (rc >= m_w);
        rej_w = (int'(proc_wr_row) >= m_h) || (int'(proc_wr_col) >= m_w);
`endif
        cur_v = (m_mode >= 2);
        cur_k = 0;
        cur_d = '0;
        if (cur_v && rej_r) begin
            cur_k = 1;
        end else if (cur_v && ref_mem.exists(int'(ra))) begin
            cur_k = 1;
            cur_d = ref_mem[int'(ra)];
        end
        if ((cur_v && rej_r) || (m_mode == 2 && proc_wr_valid && rej_w))
            m_err = 1;
        if (m_mode == 2 && proc_wr_valid && !rej_w)
            ref_mem[int'(wa)] = proc_wr_data;
        m_fl = 0;
        case (m_mode)
            1: if (in_valid) begin
                ref_mem[m_cnt] = in_pixel;
                if (m_cnt == m_np - 1) begin
                    m_fl = 1;
                    m_mode = 2;
                end
                m_cnt++;
            end
            2: if (proc_done) m_mode = 3;
            default: if (start) begin
                np = longint'(cfg_h) * cfg_w;
                if (np == 0 || np > MP) begin
                    m_err = 1;
                    m_mode = 0;
                end else begin
                    m_err = 0;
                    m_h = cfg_h;
                    m_w = cfg_w;
                    m_np = int'(np);
                    m_cnt = 0;
                    m_mode = 1;
                end
            end
        endcase
        @(posedge clk);
        #1;
        chk("mode", mode, m_mode);
        chk("in_ready", in_ready, m_mode == 1);
        chk("frame_loaded", frame_loaded, m_fl);
        chk("err", err, m_err);
        chk("rd_valid", rd_valid, pv);
        if (pv && pk) chk("rd_data", rd_data, pd);
        pv = cur_v;
        pk = cur_k;
        pd = cur_d;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int fl_cnt;
        //           rr rc  wr wc wd    wv dn  dr dc  mode v d
        tbl[0] = '{2, 3, 0, 0, 8'h00, 0, 0, 0, 0, 2, 0, 8'h00};
        tbl[1] = '{1, 1, 1, 1, 8'hAA, 1, 0, 0, 0, 2, 1, 8'd13};
        tbl[2] = '{1, 1, 0, 0, 8'h00, 0, 0, 0, 0, 2, 1, 8'd6};
        tbl[3] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 2, 1, 8'hAA};
        tbl[4] = '{0, 0, 0, 0, 8'h55, 1, 1, 0, 0, 3, 1, 8'd0};
        tbl[5] = '{0, 0, 1, 1, 8'h77, 1, 0, 3, 4, 3, 1, 8'd0};
        tbl[6] = '{0, 0, 0, 0, 8'h00, 0, 0, 0, 0, 3, 1, 8'd19};
        tbl[7] = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 3, 1, 8'h55};
        tbl[8] = '{0, 0, 0, 0, 8'h00, 0, 0, 1, 1, 3, 1, 8'hAA};

        quiet();
        model_reset();
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mode", mode, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_frame_loaded", frame_loaded, 0);
        chk("rst_err", err, 0);
        chk("rst_rd_data", rd_data, 0);
        reset = 0;

        // Load a 4x5 frame of 0..19 with idle gaps in the stream.
        cfg_h = 4; cfg_w = 5; start = 1;
        cyc();
        start = 0;
        chk("start_mode", mode, 1);
        fl_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 1) begin
                in_valid = 0; in_pixel = 8'hEE;
                cyc();
                fl_cnt += int'(frame_loaded);
            end
            in_valid = 1; in_pixel = 8'(i);
            cyc();
            fl_cnt += int'(frame_loaded);
        end
        in_valid = 0;
        chk("fl_on_last", frame_loaded, 1);
        chk("fl_count", fl_cnt, 1);
        chk("mode_proc", mode, 2);

        // PROCESS and DISPLAY vectors.
        for (int k = 0; k < 9; k++) begin
            proc_rd_row = tbl[k].rr; proc_rd_col = tbl[k].rc;
            proc_wr_row = tbl[k].wr; proc_wr_col = tbl[k].wc;
            proc_wr_data = tbl[k].wd; proc_wr_valid = tbl[k].wv;
            proc_done = tbl[k].dn;
            disp_row = tbl[k].dr; disp_col = tbl[k].dc;
            cyc();
            chk($sformatf("tbl%0d_mode", k), mode, tbl[k].e_mode);
            chk($sformatf("tbl%0d_rd_valid", k), rd_valid, tbl[k].e_v);
            if (tbl[k].e_v)
                chk($sformatf("tbl%0d_rd_data", k), rd_data, tbl[k].e_d);
        end
        quiet();

`ifdef FB_BOUNDS_CHECK_EN
        disp_row = 4; disp_col = 0;
        cyc();
        disp_row = 0;
        cyc();
        chk("oob_rd_valid", rd_valid, 1);
        chk("oob_rd_data", rd_data, 0);
        chk("oob_err", err, 1);
`endif

        // Bad configurations and start acceptance.
        cfg_h = 0; cfg_w = 16; start = 1;
        cyc();
        chk("zero_cfg_err", err, 1);
        chk("zero_cfg_mode", mode, 0);
        cfg_h = 4; cfg_w = 5;
        cyc();
        chk("good_start_err", err, 0);
        chk("good_start_mode", mode, 1);
        cfg_h = 481; cfg_w = 640;
        cyc();
        start = 0;
        chk("start_in_load_mode", mode, 1);
        chk("start_in_load_err", err, 0);

        // Reset in the middle of a load.
        in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            in_pixel = 8'(8'hC0 + i);
            cyc();
        end
        in_valid = 0;
        cyc();
        #3;
        reset = 1;
        #1;
        chk("midrst_mode", mode, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_frame_loaded", frame_loaded, 0);
        chk("midrst_rd_valid", rd_valid, 0);
        chk("midrst_rd_data", rd_data, 0);
        chk("midrst_err", err, 0);
        @(posedge clk);
        #1;
        reset = 0;
        model_reset();

        cfg_h = 481; cfg_w = 640; start = 1;
        cyc();
        start = 0;
        chk("big_cfg_err", err, 1);
        chk("big_cfg_mode", mode, 0);

        // Random traffic across all modes.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 39) == 0);
            cfg_h = CW'($urandom_range(0, 6));
            cfg_w = CW'($urandom_range(0, 6));
            in_valid = ($urandom_range(0, 3) != 0);
            in_pixel = DW'($urandom);
            proc_rd_row = CW'($urandom_range(0, 7));
            proc_rd_col = CW'($urandom_range(0, 7));
            proc_wr_row = CW'($urandom_range(0, 7));
            proc_wr_col = CW'($urandom_range(0, 7));
            proc_wr_data = DW'($urandom);
            proc_wr_valid = ($urandom_range(0, 1) == 1);
            proc_done = ($urandom_range(0, 29) == 0);
            disp_row = CW'($urandom_range(0, 7));
            disp_col = CW'($urandom_range(0, 7));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
